// File: rtl/vga_frame_monitor_if.sv
// vga_frame_monitor_if
// Bundles the monitored TinyVGA bus, the sample enable, the error clear and
// every status output of vga_frame_monitor.
//   master : the stimulus side (drives pix_en, uo_out, err_clr; observes status)
//   slave  : the monitor itself
// Signals:
//   pix_en        sample enable
//   uo_out[7:0]   monitored bus (hsync=[7], vsync=[3], R={[0],[4]}, G={[1],[5]}, B={[2],[6]})
//   err_clr       synchronous clear of err_flags
//   locked        monitor aligned to the frame
//   frame_done    one-cycle pulse per checked frame end
//   frame_crc     CRC-16 of the last completed frame
//   frame_count   completed frames
//   err_flags     sticky error bits (5 bits when VGA_MON_PIXCOUNT_EN is defined)
//   active_pixels active pixel count of the last frame (only with VGA_MON_PIXCOUNT_EN)
interface vga_frame_monitor_if;
    logic        pix_en;
    logic [7:0]  uo_out;
    logic        err_clr;
    logic        locked;
    logic        frame_done;
    logic [15:0] frame_crc;
    logic [15:0] frame_count;
`ifdef VGA_MON_PIXCOUNT_EN
    logic [4:0]  err_flags;
    logic [19:0] active_pixels;

    modport master (output pix_en, uo_out, err_clr,
                    input  locked, frame_done, frame_crc, frame_count, err_flags, active_pixels);
    modport slave  (input  pix_en, uo_out, err_clr,
                    output locked, frame_done, frame_crc, frame_count, err_flags, active_pixels);
`else
    logic [3:0]  err_flags;

    modport master (output pix_en, uo_out, err_clr,
                    input  locked, frame_done, frame_crc, frame_count, err_flags);
    modport slave  (input  pix_en, uo_out, err_clr,
                    output locked, frame_done, frame_crc, frame_count, err_flags);
`endif
endinterface

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor
// Passive monitor for the TinyVGA pinout. Locks to hsync/vsync, checks sync
// timing, flags non-black pixels in blanking and produces one CRC-16-CCITT
// (poly 0x1021, init 0xFFFF) per frame over the active pixels.
// Ports:
//   clk  pixel clock
//   rst  asynchronous active-high reset
//   mon  vga_frame_monitor_if.slave (pix_en, uo_out, err_clr in; status out)
// Optional feature macro: VGA_MON_PIXCOUNT_EN adds active_pixels and err_flags[4].
module vga_frame_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACTIVE    = 480,
    parameter bit SYNC_POL    = 1'b0
) (
    input logic               clk,
    input logic               rst,
    vga_frame_monitor_if.slave mon
);

`ifdef VGA_MON_PIXCOUNT_EN
    localparam int ERR_W = 5;
`else
    localparam int ERR_W = 4;
`endif
    localparam int HW = $clog2(H_TOTAL) + 1;
    localparam int VW = $clog2(V_TOTAL) + 1;
    localparam logic [HW-1:0] H_MAX  = '1;
    localparam logic [HW-1:0] H_ONE  = HW'(1);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SW   = HW'(H_SYNC);
    localparam logic [HW-1:0] H_A0   = HW'(H_ACT_START);
    localparam logic [HW-1:0] H_A1   = HW'(H_ACT_START + H_ACTIVE);
    localparam logic [VW-1:0] V_MAX  = '1;
    localparam logic [VW-1:0] V_ONE  = VW'(1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_TOT  = VW'(V_TOTAL);
    localparam logic [VW-1:0] V_SW   = VW'(V_SYNC);
    localparam logic [VW-1:0] V_A0   = VW'(V_ACT_START);
    localparam logic [VW-1:0] V_A1   = VW'(V_ACT_START + V_ACTIVE);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Shift one 6-bit pixel into the CRC, MSB first.
    function automatic logic [15:0] crc16_pix(input logic [15:0] crc, input logic [5:0] pix);
        logic [15:0] c;
        c = crc;
        for (int i = 5; i >= 0; i--) begin
            if (c[15] ^ pix[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    state_t            state_r, state_next_s;
    logic              hs_s, vs_s, hs_prev_r, vs_prev_r;
    logic              hs_lead_s, hs_trail_s, vs_lead_s;
    logic [5:0]        rgb_s;
    logic [HW-1:0]     h_cnt_r, h_pos_s;
    logic [VW-1:0]     v_cnt_r, v_pos_s, vs_hs_cnt_r, vs_hs_next_s;
    logic              v_period_bad_s, active_s, chk_s, frame_evt_s, enter_lock_s;
    logic              h_first_r, v_first_r, locked_r, frame_done_r;
    logic [15:0]       crc_r, crc_next_s, frame_crc_r, frame_count_r;
    logic [ERR_W-1:0]  err_r, err_new_s, err_next_s;
`ifdef VGA_MON_PIXCOUNT_EN
    logic [19:0]       pix_cnt_r, pix_cnt_next_s, active_pixels_r;
`endif

    // Sync normalisation, edge detection and pixel extraction
    always_comb begin
        hs_s       = mon.uo_out[7] ^ ~SYNC_POL;
        vs_s       = mon.uo_out[3] ^ ~SYNC_POL;
        hs_lead_s  = mon.pix_en & hs_s & ~hs_prev_r;
        hs_trail_s = mon.pix_en & ~hs_s & hs_prev_r;
        vs_lead_s  = mon.pix_en & vs_s & ~vs_prev_r;
        rgb_s      = {mon.uo_out[0], mon.uo_out[4], mon.uo_out[1],
                      mon.uo_out[5], mon.uo_out[2], mon.uo_out[6]};
    end

    // Position of the current sample: 0 on a leading edge, else saturating count
    always_comb begin
        if (hs_lead_s)              h_pos_s = '0;
        else if (h_cnt_r != H_MAX)  h_pos_s = h_cnt_r + H_ONE;
        else                        h_pos_s = h_cnt_r;

        if (vs_lead_s)                          v_pos_s = '0;
        else if (hs_lead_s && v_cnt_r != V_MAX) v_pos_s = v_cnt_r + V_ONE;
        else                                    v_pos_s = v_cnt_r;

        // hsync edges seen while vsync is asserted, restarted at each vsync edge
        if (vs_lead_s)                                         vs_hs_next_s = hs_lead_s ? V_ONE : '0;
        else if (vs_s && hs_lead_s && vs_hs_cnt_r != V_MAX)    vs_hs_next_s = vs_hs_cnt_r + V_ONE;
        else                                                   vs_hs_next_s = vs_hs_cnt_r;

        // The hsync edge coinciding with vsync closes the last line of the frame
        if (hs_lead_s) v_period_bad_s = (v_cnt_r != V_LAST);
        else           v_period_bad_s = (v_cnt_r != V_TOT);

        active_s = (h_pos_s >= H_A0) && (h_pos_s < H_A1) &&
                   (v_pos_s >= V_A0) && (v_pos_s < V_A1);
    end

    // Lock FSM next state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_SEARCH: if (vs_lead_s) state_next_s = ST_ALIGN;  else state_next_s = ST_SEARCH;
            ST_ALIGN:  if (hs_lead_s) state_next_s = ST_LOCKED; else state_next_s = ST_ALIGN;
            ST_LOCKED: state_next_s = ST_LOCKED;
            default:   state_next_s = ST_SEARCH;
        endcase
        enter_lock_s = (state_r != ST_LOCKED) && (state_next_s == ST_LOCKED);
    end

    // Timing/blanking checks, CRC step and error accumulation
    always_comb begin
        chk_s       = mon.pix_en && (state_r == ST_LOCKED);
        frame_evt_s = chk_s && vs_lead_s && !v_first_r;
        if (chk_s && active_s) crc_next_s = crc16_pix(crc_r, rgb_s);
        else                   crc_next_s = crc_r;
        err_new_s    = '0;
        err_new_s[0] = chk_s && hs_lead_s && !h_first_r && (h_cnt_r != H_LAST);
        err_new_s[1] = chk_s && hs_trail_s && (h_pos_s != H_SW);
        err_new_s[2] = frame_evt_s && (v_period_bad_s || (vs_hs_cnt_r != V_SW));
        err_new_s[3] = chk_s && (rgb_s != 6'd0) && !active_s;
`ifdef VGA_MON_PIXCOUNT_EN
        if (chk_s && active_s) pix_cnt_next_s = pix_cnt_r + 20'd1;
        else                   pix_cnt_next_s = pix_cnt_r;
        err_new_s[4] = frame_evt_s && (pix_cnt_next_s != 20'(H_ACTIVE * V_ACTIVE));
`endif
        // A clear on the same cycle as a new error keeps the new error
        if (mon.pix_en && mon.err_clr) err_next_s = err_new_s;
        else                           err_next_s = err_r | err_new_s;
    end

    // Lock FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             state_r <= ST_SEARCH;
        else if (mon.pix_en) state_r <= state_next_s;
    end

    // Counters, CRC and status registers; everything except the pulse holds while pix_en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_prev_r     <= 1'b0;
            vs_prev_r     <= 1'b0;
            h_cnt_r       <= '0;
            v_cnt_r       <= '0;
            vs_hs_cnt_r   <= '0;
            h_first_r     <= 1'b0;
            v_first_r     <= 1'b0;
            locked_r      <= 1'b0;
            frame_done_r  <= 1'b0;
            crc_r         <= 16'hFFFF;
            frame_crc_r   <= 16'h0000;
            frame_count_r <= 16'h0000;
            err_r         <= '0;
        end else begin
            frame_done_r <= frame_evt_s;
            if (mon.pix_en) begin
                hs_prev_r   <= hs_s;
                vs_prev_r   <= vs_s;
                h_cnt_r     <= h_pos_s;
                v_cnt_r     <= v_pos_s;
                vs_hs_cnt_r <= vs_hs_next_s;
                locked_r    <= (state_next_s == ST_LOCKED);
                // The first line and first frame after lock are incomplete
                if (enter_lock_s)               h_first_r <= 1'b1;
                else if (chk_s && hs_lead_s)    h_first_r <= 1'b0;
                if (enter_lock_s)               v_first_r <= 1'b1;
                else if (chk_s && vs_lead_s)    v_first_r <= 1'b0;
                if (!chk_s || vs_lead_s)        crc_r <= 16'hFFFF;
                else                            crc_r <= crc_next_s;
                if (frame_evt_s) begin
                    frame_crc_r   <= crc_next_s;
                    frame_count_r <= frame_count_r + 16'd1;
                end
                err_r <= err_next_s;
            end
        end
    end

`ifdef VGA_MON_PIXCOUNT_EN
    // Active pixel counter, latched with the frame CRC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt_r       <= 20'd0;
            active_pixels_r <= 20'd0;
        end else if (mon.pix_en) begin
            if (!chk_s || vs_lead_s) pix_cnt_r <= 20'd0;
            else                     pix_cnt_r <= pix_cnt_next_s;
            if (frame_evt_s)         active_pixels_r <= pix_cnt_next_s;
        end
    end
    assign mon.active_pixels = active_pixels_r;
`endif

    assign mon.locked      = locked_r;
    assign mon.frame_done  = frame_done_r;
    assign mon.frame_crc   = frame_crc_r;
    assign mon.frame_count = frame_count_r;
    assign mon.err_flags   = err_r;

endmodule
